// File: rtl/rr_packet_arbiter.sv
// Per-packet round-robin arbiter: N upstream stream ports share one registered downstream port.
// A winner keeps the grant until its last beat is accepted, so packets never interleave.

module rr_packet_arbiter #(
   parameter int unsigned N      = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic [N-1:0]        req_valid,
   input  logic [N*DATA_W-1:0] req_data,
   input  logic [N-1:0]        req_last,
   output logic [N-1:0]        req_ready,

   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   output logic [IDX_W-1:0]    out_src,
   input  logic                out_ready
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;

   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic [IDX_W-1:0]   out_src_q, out_src_d;

   logic [N-1:0]       mask_gt;
   logic [N-1:0]       hi_req;
   logic [IDX_W-1:0]   winner;

   logic               gnt_valid;
   logic [DATA_W-1:0]  gnt_data;
   logic               gnt_last;
   logic               out_room;
   logic               accept;

   // Lowest-index-first priority encoder; returns 0 for an all-zero vector.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   // ----------------------------------------------------------------------------------------
   // Winner selection: requesters strictly above the last-served index take priority.
   // ----------------------------------------------------------------------------------------
   always_comb begin
      mask_gt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         mask_gt[i] = (i > 32'(ptr_q));
      end
   end

   always_comb begin
      hi_req = req_valid & mask_gt;
      if (|hi_req) begin
         winner = lowest_idx(hi_req);
      end else begin
         winner = lowest_idx(req_valid);
      end
   end

   // ----------------------------------------------------------------------------------------
   // Granted-lane select and handshake.
   // ----------------------------------------------------------------------------------------
   always_comb begin
      gnt_valid = 1'b0;
      gnt_data  = '0;
      gnt_last  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt_idx_q == IDX_W'(i)) begin
            gnt_valid = req_valid[i];
            gnt_data  = req_data[i*DATA_W +: DATA_W];
            gnt_last  = req_last[i];
         end
      end
   end

   // The output register can take a beat when empty or when it drains this cycle.
   assign out_room = !out_valid_q || out_ready;
   assign accept   = (state_q == StBusy) && out_room && gnt_valid;

   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         req_ready[i] = (state_q == StBusy) && out_room && (gnt_idx_q == IDX_W'(i));
      end
   end

   // ----------------------------------------------------------------------------------------
   // Arbitration FSM.
   // ----------------------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               state_d   = StBusy;
               gnt_idx_d = winner;
            end
         end
         StBusy: begin
            if (accept && gnt_last) begin
               state_d = StIdle;
               ptr_d   = gnt_idx_q;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ----------------------------------------------------------------------------------------
   // Output register.
   // ----------------------------------------------------------------------------------------
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         out_last_d  = gnt_last;
         out_src_d   = gnt_idx_q;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         gnt_idx_q   <= '0;
         ptr_q       <= IDX_W'(N - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         gnt_idx_q   <= gnt_idx_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Randomized scoreboard bench for rr_packet_arbiter: a transaction-level model predicts grants,
// req_ready and every output beat; a separate monitor pops and compares delivered beats.

module tb_rr_packet_arbiter;

   localparam int N      = 16;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N-1:0]        req_valid;
   logic [N*DATA_W-1:0] req_data;
   logic [N-1:0]        req_last;
   logic [N-1:0]        req_ready;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic                out_last;
   logic [IDX_W-1:0]    out_src;
   logic                out_ready;

   always #5 clk = ~clk;

   rr_packet_arbiter #(.N(N), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus knobs and per-requester packet generators.
   int            len_max   = 1;
   int            valid_pct = 100;
   int            ready_pct = 100;
   logic [N-1:0]  active    = '1;
   logic [DATA_W-1:0] cur_data [N];
   int            rem [N];

   task automatic new_packet(input int i);
      rem[i]      = $urandom_range(len_max, 1);
      cur_data[i] = $urandom;
   endtask

   // Reference model: grant holder, last-served index, output-register occupancy.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic [IDX_W-1:0]  src;
   } beat_t;

   bit    m_busy;
   int    m_gnt;
   int    m_ptr;
   bit    m_full;
   beat_t sb [$];
   int    seq_n = -1;   // when >= 0, expected out_src of next delivered beat is seq_n % N

   task automatic model_reset();
      m_busy = 0;
      m_gnt  = 0;
      m_ptr  = N - 1;
      m_full = 0;
      sb.delete();
      for (int i = 0; i < N; i++) new_packet(i);
   endtask

   task automatic model_step();
      bit    room;
      bit    lst;
      beat_t b;
      room = !m_full || out_ready;
      if (m_busy) begin
         if (room && req_valid[m_gnt]) begin
            lst    = (rem[m_gnt] == 1);
            b.data = cur_data[m_gnt];
            b.last = lst;
            b.src  = IDX_W'(m_gnt);
            sb.push_back(b);
            m_full = 1;
            if (lst) begin
               m_busy = 0;
               m_ptr  = m_gnt;
               new_packet(m_gnt);
            end else begin
               rem[m_gnt]--;
               cur_data[m_gnt] = $urandom;
            end
         end else if (m_full && out_ready) begin
            m_full = 0;
         end
      end else begin
         if (m_full && out_ready) m_full = 0;
         // Rotating search starting just after the last-served requester.
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j]) begin
               m_busy = 1;
               m_gnt  = j;
               break;
            end
         end
      end
   endtask

   // One clock of stimulus: drive at negedge, check req_ready, advance the model after posedge.
   task automatic cycle();
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_valid[i]                 = active[i] && ($urandom_range(99) < valid_pct);
         req_data[i*DATA_W +: DATA_W] = cur_data[i];
         req_last[i]                  = (rem[i] == 1);
      end
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      exp_rdy = '0;
      if (m_busy && (!m_full || out_ready)) exp_rdy[m_gnt] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      @(posedge clk);
      #1;
      if (rst_n) model_step();
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) cycle();
   endtask

   // Monitor: compares every delivered beat with the scoreboard and checks stall stability.
   bit    prev_stall = 0;
   beat_t prev_beat;

   always begin
      beat_t b;
      beat_t cur;
      @(negedge clk);
      #1;
      cur.data = out_data;
      cur.last = out_last;
      cur.src  = out_src;
      chk("out_valid", out_valid, m_full);
      if (rst_n && prev_stall) begin
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_hold", cur, prev_beat);
      end
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got beat %0h expected none at %0t", cur, $time);
         end else begin
            b = sb.pop_front();
            chk("out_data", out_data, b.data);
            chk("out_last", out_last, b.last);
            chk("out_src", out_src, b.src);
            if (seq_n >= 0) begin
               chk("rotation", out_src, seq_n % N);
               seq_n++;
            end
         end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_beat  = cur;
   end

   initial begin
      bit found;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b0;
      model_reset();

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_src", out_src, '0);
      chk("rst_req_ready", req_ready, '0);
      #1 rst_n = 1'b1;

      // All valid, single-beat packets, no backpressure: strict rotation from 0.
      seq_n = 0;
      run(40);
      seq_n = -1;

      // Only requesters 3 and 9 contend.
      len_max = 3;
      active  = '0;
      active[3] = 1'b1;
      active[9] = 1'b1;
      run(60);

      // Fully random traffic with valid gaps and backpressure.
      len_max   = 4;
      valid_pct = 70;
      ready_pct = 60;
      for (int p = 0; p < 8; p++) begin
         active = N'($urandom);
         run(200);
      end

      // Asynchronous reset in the middle of a buffered packet.
      active    = '1;
      valid_pct = 100;
      ready_pct = 50;
      found     = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         cycle();
         found = m_busy && m_full;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL reset_setup: got no busy state expected busy within 200 cycles");
      end
      @(negedge clk);
      #2;
      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_req_ready", req_ready, '0);
      len_max   = 1;
      ready_pct = 100;
      model_reset();
      seq_n = 0;
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      run(20);
      seq_n = -1;

      // More random traffic, then drain the output register.
      len_max   = 4;
      valid_pct = 80;
      ready_pct = 70;
      run(600);
      active    = '0;
      ready_pct = 100;
      run(5);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
